// File: rtl/riscv_wb_pkg.sv
// Shared types and instruction field positions for the writeback stage.
package riscv_wb_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  localparam int unsigned OPC_LSB    = 0;
  localparam int unsigned OPC_MSB    = 6;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned RD_MSB     = 11;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_MSB = 14;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS1_MSB    = 19;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned RS2_MSB    = 24;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_MSB = 31;

  localparam int unsigned PKT_INSTR_LSB  = 32;
  localparam int unsigned PKT_INSTR_MSB  = 63;
  localparam int unsigned PKT_RESULT_LSB = 0;
  localparam int unsigned PKT_RESULT_MSB = 31;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] result;
    logic        writable;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RETIRE = 2'd2
  } wb_state_e;

  function automatic logic is_writable(input logic [31:0] instr);
    return (instr[OPC_MSB:OPC_LSB] == OPC_RTYPE) && (instr[RD_MSB:RD_LSB] != 5'd0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO of writeback entries.
// With WB_FWD_EN defined, exposes all entries in age order (slot 0 = head).
module wb_fifo
  import riscv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rstn,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
`ifdef WB_FWD_EN
  ,
  output logic [DEPTH*$bits(wb_entry_t)-1:0] view_flat,
  output logic [DEPTH-1:0]                   view_valid
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = $bits(wb_entry_t);

  wb_entry_t   mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_entry;
  end

`ifdef WB_FWD_EN
  logic [AW:0] count;
  assign count = wptr_q - rptr_q;

  always_comb begin
    view_flat  = '0;
    view_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      view_flat[i*EW +: EW] = mem_q[rptr_q[AW-1:0] + AW'(i)];
      view_valid[i]         = ((AW+1)'(i) < count);
    end
  end
`endif

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: buffers decode packets, commits R-type results via req/ack.
// Optional register forwarding lookup enabled by defining WB_FWD_EN.
module writeback_stage
  import riscv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [63:0]      wb_reg,
  input  logic             wb_valid,
  output logic             wb_ready,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic [31:0]      wr_data,
  input  logic             wr_ack,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] drop_count,
  input  logic [4:0]       fwd_rs,
  output logic             fwd_hit,
  output logic [31:0]      fwd_data
);

  localparam int unsigned EW = $bits(wb_entry_t);

  wb_entry_t push_entry, head;
  logic      full, empty, push, pop;
  wb_state_e state_q;

  assign wb_ready = !full;
  assign push     = wb_valid && !full;

  always_comb begin
    push_entry          = '0;
    push_entry.instr    = wb_reg[PKT_INSTR_MSB:PKT_INSTR_LSB];
    push_entry.result   = wb_reg[PKT_RESULT_MSB:PKT_RESULT_LSB];
    push_entry.writable = is_writable(wb_reg[PKT_INSTR_MSB:PKT_INSTR_LSB]);
  end

`ifdef WB_FWD_EN
  logic [DEPTH*EW-1:0] view_flat;
  logic [DEPTH-1:0]    view_valid;
`endif

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty)
`ifdef WB_FWD_EN
    ,
    .view_flat  (view_flat),
    .view_valid (view_valid)
`endif
  );

  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      IDLE:    pop = !empty && !head.writable;
      REQ:     pop = wr_ack;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= IDLE;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      retire_count <= '0;
      drop_count   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            if (head.writable) begin
              wr_en   <= 1'b1;
              wr_addr <= head.instr[RD_MSB:RD_LSB];
              wr_data <= head.result;
              state_q <= REQ;
            end else begin
              drop_count <= drop_count + CNT_W'(1);
            end
          end
        end
        REQ: begin
          if (wr_ack) begin
            wr_en        <= 1'b0;
            retire_count <= retire_count + CNT_W'(1);
            state_q      <= RETIRE;
          end
        end
        RETIRE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WB_FWD_EN
  wb_entry_t view_e [DEPTH];
  logic      unused_view;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) view_e[i] = view_flat[i*EW +: EW];
  end

  // The in-flight REQ entry is still the FIFO head, so scanning oldest to
  // youngest covers it and leaves the youngest match in fwd_data.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (view_valid[i] && view_e[i].writable && (fwd_rs != 5'd0) &&
          (view_e[i].instr[RD_MSB:RD_LSB] == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = view_e[i].result;
      end
    end
  end

  always_comb begin
    unused_view = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) unused_view = unused_view ^ (^view_e[i].instr);
  end
`else
  logic unused_fwd_rs;
  assign unused_fwd_rs = ^fwd_rs;
  assign fwd_hit       = 1'b0;
  assign fwd_data      = '0;
`endif

  logic unused_head_instr;
  assign unused_head_instr = ^{head.instr[31:RD_MSB+1], head.instr[RD_LSB-1:0]};

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (default and WB_FWD_EN builds).
module tb_writeback_stage;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 32;
`ifdef WB_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_rstn = 1'b0;
  logic [63:0]      wb_reg = '0;
  logic             wb_valid = 1'b0;
  logic             wb_ready;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             wr_ack = 1'b0;
  logic [CNT_W-1:0] retire_count;
  logic [CNT_W-1:0] drop_count;
  logic [4:0]       fwd_rs = '0;
  logic             fwd_hit;
  logic [31:0]      fwd_data;

  int n_checks = 0;
  int n_fails  = 0;

  writeback_stage #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .wb_reg       (wb_reg),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .retire_count (retire_count),
    .drop_count   (drop_count),
    .fwd_rs       (fwd_rs),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rstn   = 1'b0;
    wb_valid = 1'b0;
    wr_ack   = 1'b0;
    wb_reg   = '0;
    fwd_rs   = '0;
    step();
    step();
    i_rstn = 1'b1;
    step();
  endtask

  task automatic push_one(input logic [63:0] pkt);
    wb_reg   = pkt;
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
  endtask

  // add rd, x1, x2 with the given result
  function automatic logic [63:0] rtype(input logic [4:0] rd, input logic [31:0] res);
    logic [31:0] ins;
    ins = 32'h0020_8033 | (32'(rd) << 7);
    return {ins, res};
  endfunction

  initial begin
    int n_wr;
    int first_idx;
    int first_ready;
    bit push_now;
    bit seen;
    logic [4:0]  got_addr [8];
    logic [31:0] got_data [8];
    int          got_idx  [8];
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    // Reset then idle
    do_reset();
    check_eq("rst_ready", 32'(wb_ready), 32'd1);
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", wr_data, 32'd0);
    check_eq("rst_retire", retire_count, 32'd0);
    check_eq("rst_drop", drop_count, 32'd0);
    check_eq("rst_fwd_hit", 32'(fwd_hit), 32'd0);

    // Single ADD x3 with ack tied high
    do_reset();
    wr_ack = 1'b1;
    push_one({32'h0020_81B3, 32'h0000_0007});
    n_wr = 0;
    first_idx = -1;
    last_addr = '0;
    last_data = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wr_en) begin
        if (first_idx < 0) first_idx = i;
        n_wr++;
        last_addr = wr_addr;
        last_data = wr_data;
      end
    end
    check_eq("add_wr_cycles", 32'(n_wr), 32'd1);
    check_eq("add_latency", 32'(first_idx), 32'd0);
    check_eq("add_wr_addr", 32'(last_addr), 32'd3);
    check_eq("add_wr_data", last_data, 32'd7);
    check_eq("add_retire", retire_count, 32'd1);
    check_eq("add_drop", drop_count, 32'd0);

    // Drop path: load, then R-type to x0
    do_reset();
    wr_ack   = 1'b1;
    wb_reg   = {32'h0000_A183, 32'h0000_00AA};
    wb_valid = 1'b1;
    step();
    wb_reg = {32'h0020_8033, 32'h0000_00BB};
    step();
    wb_valid = 1'b0;
    check_eq("drop_rate", drop_count, 32'd1);
    n_wr = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (wr_en) n_wr++;
    end
    check_eq("drop_no_wr", 32'(n_wr), 32'd0);
    check_eq("drop_count", drop_count, 32'd2);
    check_eq("drop_retire", retire_count, 32'd0);

    // Backpressure: four writable packets with ack low, fifth held
    do_reset();
    wr_ack = 1'b0;
    for (int r = 1; r <= 4; r++) push_one(rtype(5'(r), 32'h11 * 32'(r)));
    check_eq("bp_full_ready", 32'(wb_ready), 32'd0);
    wb_reg   = rtype(5'd5, 32'h55);
    wb_valid = 1'b1;
    step();
    check_eq("bp_hold_ready", 32'(wb_ready), 32'd0);
    step();
    check_eq("bp_hold_wr_en", 32'(wr_en), 32'd1);
    check_eq("bp_hold_addr", 32'(wr_addr), 32'd1);
    wr_ack = 1'b1;
    n_wr = 0;
    first_ready = -1;
    for (int i = 0; i < 20; i++) begin
      if (wr_en) begin
        if (n_wr < 8) begin
          got_addr[n_wr] = wr_addr;
          got_data[n_wr] = wr_data;
          got_idx[n_wr]  = i;
        end
        n_wr++;
      end
      if (wb_ready && first_ready < 0) first_ready = i;
      push_now = wb_valid && wb_ready;
      step();
      if (push_now) wb_valid = 1'b0;
    end
    check_eq("bp_n_writes", 32'(n_wr), 32'd5);
    check_eq("bp_ready_return", 32'(first_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k < n_wr) begin
        check_eq($sformatf("bp_addr%0d", k), 32'(got_addr[k]), 32'(k + 1));
        check_eq($sformatf("bp_data%0d", k), got_data[k], 32'h11 * 32'(k + 1));
        check_eq($sformatf("bp_slot%0d", k), 32'(got_idx[k]), 32'(3 * k));
      end
    end
    check_eq("bp_retire", retire_count, 32'd5);
    check_eq("bp_valid_taken", 32'(wb_valid), 32'd0);

    // Reset asserted while a write is pending
    do_reset();
    wr_ack = 1'b0;
    push_one(rtype(5'd7, 32'h77));
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!seen) begin
        if (wr_en) seen = 1'b1;
        else step();
      end
    end
    check_eq("mrst_req_seen", 32'(seen), 32'd1);
    i_rstn = 1'b0;
    #1;
    check_eq("mrst_wr_en_async", 32'(wr_en), 32'd0);
    check_eq("mrst_wr_addr", 32'(wr_addr), 32'd0);
    step();
    i_rstn = 1'b1;
    step();
    wr_ack = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (wr_en) n_wr++;
    end
    check_eq("mrst_no_wr", 32'(n_wr), 32'd0);
    check_eq("mrst_retire", retire_count, 32'd0);
    check_eq("mrst_drop", drop_count, 32'd0);
    check_eq("mrst_ready", 32'(wb_ready), 32'd1);

    // Forwarding lookup: x5 <- 11, x5 <- 22, x6 <- 33, then a load to x5
    do_reset();
    wr_ack = 1'b0;
    push_one(rtype(5'd5, 32'd11));
    push_one(rtype(5'd5, 32'd22));
    push_one(rtype(5'd6, 32'd33));
    push_one({32'h0000_A283, 32'd99});
    fwd_rs = 5'd5;
    #1;
    check_eq("fwd_x5_hit", 32'(fwd_hit), FwdEn ? 32'd1 : 32'd0);
    check_eq("fwd_x5_data", fwd_data, FwdEn ? 32'd22 : 32'd0);
    fwd_rs = 5'd6;
    #1;
    check_eq("fwd_x6_data", fwd_data, FwdEn ? 32'd33 : 32'd0);
    fwd_rs = 5'd0;
    #1;
    check_eq("fwd_x0_hit", 32'(fwd_hit), 32'd0);
    fwd_rs = 5'd9;
    #1;
    check_eq("fwd_x9_hit", 32'(fwd_hit), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
